mem_arbiter: RTL

Sits directly downstream of the cpu core. It merges the core's instruction-memory and data-memory request ports into one shared memory bus port, which drives a single-ported RAM or bus bridge. Each side's request is captured into a pending slot and arbitrated round-robin. The winning request is presented on the memory port, and the response is routed back to the requester as a one-cycle ready pulse.

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_arbiter_slot.sv | 63 ++++++
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared types for the instruction/data memory arbiter.
//   mem_slot_type : one pending request (busy flag plus the bus payload)
//   arb_state_e   : arbiter FSM states
//   INSTR / DATA  : grant encoding used by the round-robin pointer
package mem_arbiter_pkg;

   localparam int unsigned MEM_ADDR_W = 32;
   localparam int unsigned MEM_DATA_W = 32;
   localparam int unsigned MEM_STRB_W = MEM_DATA_W / 8;

   typedef struct packed {
      logic                  busy;
      logic                  instr;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] wdata;
      logic [MEM_STRB_W-1:0] wstrb;
   } mem_slot_type;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } arb_state_e;

   localparam logic INSTR = 1'b0;
   localparam logic DATA  = 1'b1;

endpackage

// File: rtl/mem_arbiter_slot.sv
// mem_arbiter_slot
// One pending-request register for one side of the arbiter.
// A valid request loads the slot unless it is still occupied. Occupied means
// busy and not being released by the arbiter on this same edge. A request
// that hits an occupied slot is dropped and raises the sticky overrun flag.
// Ports:
//   clock, reset          : clock, synchronous active-low reset
//   valid_i .. wstrb_i    : request from the cpu side
//   free_i                : arbiter completes this slot on the current edge
//   slot_o                : registered slot contents
//   overrun_o             : sticky dropped-request flag
module mem_arbiter_slot
   import mem_arbiter_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  valid_i,
   input  logic                  instr_i,
   input  logic [MEM_ADDR_W-1:0] addr_i,
   input  logic [MEM_DATA_W-1:0] wdata_i,
   input  logic [MEM_STRB_W-1:0] wstrb_i,
   input  logic                  free_i,
   output mem_slot_type          slot_o,
   output logic                  overrun_o
);

   mem_slot_type slot_q, slot_d;
   logic         overrun_q, overrun_d;

   always_comb begin
      slot_d    = slot_q;
      overrun_d = overrun_q;
      if (free_i) begin
         slot_d.busy = 1'b0;
      end
      if (valid_i) begin
         // A slot released on this edge can be reloaded on the same edge.
         if (slot_q.busy && !free_i) begin
            overrun_d = 1'b1;
         end else begin
            slot_d.busy  = 1'b1;
            slot_d.instr = instr_i;
            slot_d.addr  = addr_i;
            slot_d.wdata = wdata_i;
            slot_d.wstrb = wstrb_i;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         slot_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         slot_q    <= slot_d;
         overrun_q <= overrun_d;
      end
   end

   assign slot_o    = slot_q;
   assign overrun_o = overrun_q;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Merges the cpu instruction and data memory ports onto one shared memory
// port. Each side's request is held in a pending slot. The two slots are
// granted round-robin. A response returns to its requester as a one-cycle
// ready pulse with the registered read data.
// Ports:
//   clock, reset                 : clock, synchronous active-low reset
//   imemory_* (valid..wstrb in)  : instruction-side request
//   imemory_rdata/ready (out)    : instruction-side response
//   dmemory_* / dmemory_rdata/ready : data-side request / response
//   memory_* (valid..wstrb out)  : shared bus request (registered)
//   memory_rdata/ready (in)      : shared bus response
//   overrun                      : sticky, a request hit an occupied slot
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = MEM_ADDR_W,
   parameter int unsigned DATA_WIDTH = MEM_DATA_W
) (
   input  logic                    reset,
   input  logic                    clock,
   input  logic                    imemory_valid,
   input  logic                    imemory_instr,
   input  logic [ADDR_WIDTH-1:0]   imemory_addr,
   input  logic [DATA_WIDTH-1:0]   imemory_wdata,
   input  logic [DATA_WIDTH/8-1:0] imemory_wstrb,
   output logic [DATA_WIDTH-1:0]   imemory_rdata,
   output logic                    imemory_ready,
   input  logic                    dmemory_valid,
   input  logic                    dmemory_instr,
   input  logic [ADDR_WIDTH-1:0]   dmemory_addr,
   input  logic [DATA_WIDTH-1:0]   dmemory_wdata,
   input  logic [DATA_WIDTH/8-1:0] dmemory_wstrb,
   output logic [DATA_WIDTH-1:0]   dmemory_rdata,
   output logic                    dmemory_ready,
   output logic                    memory_valid,
   output logic                    memory_instr,
   output logic [ADDR_WIDTH-1:0]   memory_addr,
   output logic [DATA_WIDTH-1:0]   memory_wdata,
   output logic [DATA_WIDTH/8-1:0] memory_wstrb,
   input  logic [DATA_WIDTH-1:0]   memory_rdata,
   input  logic                    memory_ready,
   output logic                    overrun
);

   mem_slot_type islot, dslot;
   logic         ifree, dfree;
   logic         iovr, dovr;

   arb_state_e              state_q;
   logic                    last_grant_q;
   logic                    mem_valid_q;
   logic                    mem_instr_q;
   logic [ADDR_WIDTH-1:0]   mem_addr_q;
   logic [DATA_WIDTH-1:0]   mem_wdata_q;
   logic [DATA_WIDTH/8-1:0] mem_wstrb_q;
   logic [DATA_WIDTH-1:0]   irdata_q, drdata_q;
   logic                    iready_q, dready_q;

   // A slot is released on the edge its granted transaction completes.
   assign ifree = (state_q == GRANT_I) && memory_ready;
   assign dfree = (state_q == GRANT_D) && memory_ready;

   mem_arbiter_slot u_islot (
      .clock     (clock),
      .reset     (reset),
      .valid_i   (imemory_valid),
      .instr_i   (imemory_instr),
      .addr_i    (imemory_addr),
      .wdata_i   (imemory_wdata),
      .wstrb_i   (imemory_wstrb),
      .free_i    (ifree),
      .slot_o    (islot),
      .overrun_o (iovr)
   );

   mem_arbiter_slot u_dslot (
      .clock     (clock),
      .reset     (reset),
      .valid_i   (dmemory_valid),
      .instr_i   (dmemory_instr),
      .addr_i    (dmemory_addr),
      .wdata_i   (dmemory_wdata),
      .wstrb_i   (dmemory_wstrb),
      .free_i    (dfree),
      .slot_o    (dslot),
      .overrun_o (dovr)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_grant_q <= INSTR;
         mem_valid_q  <= 1'b0;
         mem_instr_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wstrb_q  <= '0;
         irdata_q     <= '0;
         drdata_q     <= '0;
         iready_q     <= 1'b0;
         dready_q     <= 1'b0;
      end else begin
         iready_q <= 1'b0;
         dready_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // The instruction side wins when it is alone, or when both
               // are waiting and data won last time. last_grant tracks every
               // winner, so contention alternates.
               if (islot.busy && (!dslot.busy || last_grant_q == DATA)) begin
                  state_q      <= GRANT_I;
                  last_grant_q <= INSTR;
                  mem_valid_q  <= 1'b1;
                  mem_instr_q  <= islot.instr;
                  mem_addr_q   <= islot.addr;
                  mem_wdata_q  <= islot.wdata;
                  mem_wstrb_q  <= islot.wstrb;
               end else if (dslot.busy) begin
                  state_q      <= GRANT_D;
                  last_grant_q <= DATA;
                  mem_valid_q  <= 1'b1;
                  mem_instr_q  <= dslot.instr;
                  mem_addr_q   <= dslot.addr;
                  mem_wdata_q  <= dslot.wdata;
                  mem_wstrb_q  <= dslot.wstrb;
               end
            end
            GRANT_I: begin
               if (memory_ready) begin
                  state_q     <= IDLE;
                  mem_valid_q <= 1'b0;
                  irdata_q    <= memory_rdata;
                  iready_q    <= 1'b1;
               end
            end
            GRANT_D: begin
               if (memory_ready) begin
                  state_q     <= IDLE;
                  mem_valid_q <= 1'b0;
                  drdata_q    <= memory_rdata;
                  dready_q    <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign memory_valid  = mem_valid_q;
   assign memory_instr  = mem_instr_q;
   assign memory_addr   = mem_addr_q;
   assign memory_wdata  = mem_wdata_q;
   assign memory_wstrb  = mem_wstrb_q;
   assign imemory_rdata = irdata_q;
   assign imemory_ready = iready_q;
   assign dmemory_rdata = drdata_q;
   assign dmemory_ready = dready_q;
   assign overrun       = iovr | dovr;

endmodule
